// File: rtl/clkgate_pkg.sv
// clkgate_pkg: shared types and default sizing for the clock-gated RAM arbiter.
package clkgate_pkg;

    // FSM encoding; values are fixed because other blocks decode them.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAKE   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    // Default geometry and gate-close delay (HOLD_CYC legal range 1..15).
    localparam int CLKGATE_AW       = 4;
    localparam int CLKGATE_DW       = 8;
    localparam int CLKGATE_HOLD_CYC = 4;

    // Round-robin pointer values.
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/clkgate_cell.sv
// clkgate_cell: glitch-free clock gate. The enable is captured by a latch
// that is open only while clk is low, so it can never change while clk is
// high and the AND output cannot produce a runt pulse.
module clkgate_cell (
    input  logic clk,
    input  logic en,
    output logic gclk
);

    logic en_lat_r;

    // Transparent-low enable latch.
    always_latch begin
        if (!clk) begin
            en_lat_r <= en;
        end
    end

    assign gclk = clk & en_lat_r;

endmodule

// File: rtl/clkgate_arb.sv
// clkgate_arb: two-requester round-robin front end for a single-port RAM.
// The RAM clock is gated off after HOLD_CYC request-free cycles and is woken
// with one WAKE cycle before accesses resume. Grants, acks and the RAM command
// are decoded in the same cycle as the request so back-to-back traffic runs
// at one access per cycle.
// Optional build macro: CLKGATE_ARB_STATS_EN adds the gated_cycles counter.
module clkgate_arb
    import clkgate_pkg::*;
#(
    parameter int AW       = CLKGATE_AW,
    parameter int DW       = CLKGATE_DW,
    parameter int HOLD_CYC = CLKGATE_HOLD_CYC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_wr,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_wr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic          gclk,
    output logic          ram_en,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_d,
`ifdef CLKGATE_ARB_STATS_EN
    output logic [15:0]   gated_cycles,
`endif
    input  logic [DW-1:0] ram_q
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_CYC);

    state_e        state_r;
    state_e        state_n;
    logic [3:0]    hold_cnt_r;
    logic [3:0]    hold_cnt_n;
    logic [3:0]    hold_inc_s;
    logic          rr_r;
    logic          rr_n;
    logic          gate_en_r;
    logic          gate_en_n;
    logic          cell_en_s;
    logic          a_rv_r;
    logic          b_rv_r;
    logic          a_rv_n;
    logic          b_rv_n;
    logic [AW-1:0] addr_last_r;
    logic [DW-1:0] data_last_r;
    logic          grant_a_s;
    logic          grant_b_s;
    logic          grant_any_s;

    // Round-robin arbitration; grants only while the gate is fully open.
    // Grants are suppressed during reset so no requester sees a lost ack.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if ((state_r == ACTIVE) && !rst) begin
            if (a_req && b_req) begin
                if (rr_r == RR_A) begin
                    grant_a_s = 1'b1;
                end else begin
                    grant_b_s = 1'b1;
                end
            end else begin
                grant_a_s = a_req;
                grant_b_s = b_req;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign grant_any_s = grant_a_s | grant_b_s;
    assign hold_inc_s  = hold_cnt_r + 4'd1;

    // Next state, hold counter and round-robin pointer.
    always_comb begin
        state_n    = state_r;
        hold_cnt_n = hold_cnt_r;
        rr_n       = rr_r;
        case (state_r)
            IDLE: begin
                hold_cnt_n = 4'd0;
                if (a_req || b_req) begin
                    state_n = WAKE;
                end else begin
                    state_n = IDLE;
                end
            end
            WAKE: begin
                hold_cnt_n = 4'd0;
                state_n    = ACTIVE;
            end
            ACTIVE: begin
                if (grant_any_s) begin
                    // A request in the closing cycle still wins and keeps us awake.
                    hold_cnt_n = 4'd0;
                    rr_n       = grant_a_s ? RR_B : RR_A;
                    state_n    = ACTIVE;
                end else if (hold_inc_s == HOLD_LIM) begin
                    hold_cnt_n = 4'd0;
                    state_n    = IDLE;
                end else begin
                    hold_cnt_n = hold_inc_s;
                    state_n    = ACTIVE;
                end
            end
            default: begin
                hold_cnt_n = 4'd0;
                state_n    = IDLE;
            end
        endcase
    end

    // RAM command and acks for the current winner; address/data hold when idle.
    always_comb begin
        a_ack    = grant_a_s;
        b_ack    = grant_b_s;
        ram_en   = grant_any_s;
        ram_wr   = 1'b0;
        ram_addr = addr_last_r;
        ram_d    = data_last_r;
        if (grant_a_s) begin
            ram_wr   = a_wr;
            ram_addr = a_addr;
            ram_d    = a_wdata;
        end else if (grant_b_s) begin
            ram_wr   = b_wr;
            ram_addr = b_addr;
            ram_d    = b_wdata;
        end else begin
            ram_wr   = 1'b0;
            ram_addr = addr_last_r;
            ram_d    = data_last_r;
        end
    end

    assign a_rv_n = grant_a_s & ~a_wr;
    assign b_rv_n = grant_b_s & ~b_wr;

    // Keep the gate open whenever we are awake or a read result is still due.
    assign gate_en_n = (state_n != IDLE) | a_rv_n | b_rv_n;

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            hold_cnt_r  <= 4'd0;
            rr_r        <= RR_A;
            gate_en_r   <= 1'b0;
            a_rv_r      <= 1'b0;
            b_rv_r      <= 1'b0;
            addr_last_r <= {AW{1'b0}};
            data_last_r <= {DW{1'b0}};
        end else begin
            state_r     <= state_n;
            hold_cnt_r  <= hold_cnt_n;
            rr_r        <= rr_n;
            gate_en_r   <= gate_en_n;
            a_rv_r      <= a_rv_n;
            b_rv_r      <= b_rv_n;
            addr_last_r <= ram_addr;
            data_last_r <= ram_d;
        end
    end

    // A reset landing on the cycle a read result is due drops that result.
    assign a_rvalid = a_rv_r & ~rst;
    assign b_rvalid = b_rv_r & ~rst;
    assign rdata    = (a_rvalid | b_rvalid) ? ram_q : {DW{1'b0}};

    // Reset closes the gate before the next rising edge reaches the RAM.
    assign cell_en_s = gate_en_r & ~rst;

    clkgate_cell u_clkgate_cell (
        .clk  (clk),
        .en   (cell_en_s),
        .gclk (gclk)
    );

`ifdef CLKGATE_ARB_STATS_EN
    logic [15:0] gated_cnt_r;

    // Saturating count of cycles spent with the gate enable low.
    always_ff @(posedge clk) begin
        if (rst) begin
            gated_cnt_r <= 16'd0;
        end else if (!gate_en_r) begin
            gated_cnt_r <= sat_inc16(gated_cnt_r);
        end else begin
            gated_cnt_r <= gated_cnt_r;
        end
    end

    assign gated_cycles = gated_cnt_r;
`endif

endmodule

// File: tb/tb_clkgate_arb.sv
// tb_clkgate_arb: directed and randomized checks of clkgate_arb against a
// cycle-level reference model of the requester/RAM protocol. A small RAM
// clocked by gclk sits behind the DUT so the gate itself is exercised.
module tb_clkgate_arb;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int HOLD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_wr, b_req, b_wr;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, a_rvalid, b_ack, b_rvalid;
    logic [DW-1:0] rdata;
    logic          gclk, ram_en, ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;
`ifdef CLKGATE_ARB_STATS_EN
    logic [15:0]   gated_cycles;
`endif

    clkgate_arb #(.AW(AW), .DW(DW), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid),
        .rdata(rdata), .gclk(gclk), .ram_en(ram_en), .ram_wr(ram_wr),
        .ram_addr(ram_addr), .ram_d(ram_d),
`ifdef CLKGATE_ARB_STATS_EN
        .gated_cycles(gated_cycles),
`endif
        .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // RAM behind the gated clock; the command is captured while it is stable.
    logic [DW-1:0] ram_mem [16];
    logic          cap_en, cap_wr;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_d;
    always @(negedge clk) begin
        cap_en   = ram_en;
        cap_wr   = ram_wr;
        cap_addr = ram_addr;
        cap_d    = ram_d;
    end
    always @(posedge gclk) begin
        if (cap_en) begin
            if (cap_wr) ram_mem[cap_addr] <= cap_d;
            else        ram_q <= ram_mem[cap_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 asleep, 1 waking, 2 awake.
    int            m_phase, m_quiet, m_gated;
    bit            m_tie_b, m_rv_a, m_rv_b, m_rv_known;
    logic [DW-1:0] m_rv_data;
    logic [DW-1:0] m_mem [16];
    bit            m_known [16];
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_last_d;

    logic          e_a_ack, e_b_ack, e_en, e_wr, e_a_rv, e_b_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_d;

    // Expected combinational response for the current inputs and model state.
    function automatic void model_eval();
        bit ga, gb;
        ga = 1'b0;
        gb = 1'b0;
        if (m_phase == 2 && !rst) begin
            if (a_req && b_req) begin
                ga = !m_tie_b;
                gb = m_tie_b;
            end else begin
                ga = a_req;
                gb = b_req;
            end
        end
        e_a_ack = ga;
        e_b_ack = gb;
        e_en    = ga | gb;
        e_wr    = ga ? a_wr : (gb ? b_wr : 1'b0);
        e_addr  = ga ? a_addr : (gb ? b_addr : m_last_addr);
        e_d     = ga ? a_wdata : (gb ? b_wdata : m_last_d);
        e_a_rv  = m_rv_a && !rst;
        e_b_rv  = m_rv_b && !rst;
    endfunction

    // Advance the model across one rising edge.
    function automatic void model_clock();
        model_eval();
        if (rst) begin
            m_phase = 0; m_quiet = 0; m_tie_b = 1'b0; m_gated = 0;
            m_rv_a = 1'b0; m_rv_b = 1'b0; m_last_addr = '0; m_last_d = '0;
            return;
        end
        if (m_phase == 0 && !(m_rv_a || m_rv_b) && m_gated < 65535) m_gated++;
        m_rv_a = e_a_ack && !a_wr;
        m_rv_b = e_b_ack && !b_wr;
        if (e_en) begin
            m_last_addr = e_addr;
            m_last_d    = e_d;
            if (e_wr) begin
                m_mem[e_addr]   = e_d;
                m_known[e_addr] = 1'b1;
            end else begin
                m_rv_data  = m_mem[e_addr];
                m_rv_known = m_known[e_addr];
            end
            m_tie_b = e_a_ack;
        end
        if (m_phase == 0) begin
            if (a_req || b_req) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_quiet = 0;
        end else if (e_en) begin
            m_quiet = 0;
        end else begin
            m_quiet++;
            if (m_quiet == HOLD) begin
                m_phase = 0;
                m_quiet = 0;
            end
        end
    endfunction

    function automatic logic [17:0] obs_vec();
        return {a_ack, b_ack, ram_en, ram_wr, a_rvalid, b_rvalid, ram_addr, ram_d};
    endfunction

    function automatic logic [17:0] exp_vec();
        return {e_a_ack, e_b_ack, e_en, e_wr, e_a_rv, e_b_rv, e_addr, e_d};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic settle();
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < HOLD + 4; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        model_eval();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset_outputs: got %h want %h", obs_vec(), exp_vec());
        end
        n_vec++;
        if ({dut.state_r, rdata, ram_addr, ram_d} !== {2'd0, 8'h00, 4'h0, 8'h00}) begin
            n_err++; $display("FAIL reset_state: state %0d rdata %h addr %h d %h", dut.state_r, rdata, ram_addr, ram_d);
        end
        tick();
        n_vec++;
        if (gclk !== 1'b0) begin
            n_err++; $display("FAIL reset_gclk: got %b want 0", gclk);
        end
    endtask

    task automatic test_single_write();
        bit acked;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 4'h3; a_wdata = 8'hA5;
        for (int c = 0; c < HOLD + 5; c++) begin
            @(negedge clk);
            model_eval();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL write_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 1) begin
                n_vec++;
                if (dut.state_r !== 2'd1) begin
                    n_err++; $display("FAIL write_wake: state %0d want 1", dut.state_r);
                end
            end
            if (c == 2) begin
                n_vec++;
                if ({a_ack, ram_en, ram_wr, ram_addr, ram_d} !== {3'b111, 4'h3, 8'hA5}) begin
                    n_err++; $display("FAIL write_grant: got %b%b%b %h %h want 111 3 a5", a_ack, ram_en, ram_wr, ram_addr, ram_d);
                end
            end
            if (c == HOLD + 3) begin
                n_vec++;
                if (dut.state_r !== 2'd0) begin
                    n_err++; $display("FAIL write_idle: state %0d want 0", dut.state_r);
                end
            end
            acked = e_a_ack;
            tick();
            if (acked) a_req = 1'b0;
        end
    endtask

    task automatic test_read_back();
        bit ack_prev = 1'b0;
        bit seen = 1'b0;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 4'h3; b_wdata = 8'h00;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            model_eval();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL readback_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (ack_prev) begin
                seen = 1'b1;
                n_vec++;
                if ({b_rvalid, rdata} !== {1'b1, 8'hA5}) begin
                    n_err++; $display("FAIL readback_data: rvalid %b rdata %h want 1 a5", b_rvalid, rdata);
                end
            end
            ack_prev = e_b_ack;
            tick();
            if (ack_prev) b_req = 1'b0;
        end
        if (!seen) begin
            n_vec++; n_err++; $display("FAIL readback_timeout: got no ack want ack");
        end
        settle();
    endtask

    task automatic test_contention();
        int k = 0;
        a_req = 1'b1; b_req = 1'b1;
        a_wr = 1'b1; b_wr = 1'b1;
        a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
        b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
        for (int c = 0; c < 12 && k < 6; c++) begin
            @(negedge clk);
            model_eval();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL contention_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (a_ack || b_ack) begin
                n_vec++;
                if ({a_ack, b_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL contention_order%0d: got %b want %b", k, {a_ack, b_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
                end
                k++;
            end else if (k > 0) begin
                n_vec++; n_err++; $display("FAIL contention_bubble: got no ack want ack at grant %0d", k);
            end
            tick();
            a_wr = 1'($urandom_range(0, 1)); a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
            b_wr = 1'($urandom_range(0, 1)); b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
        end
        n_vec++;
        if (k != 6) begin
            n_err++; $display("FAIL contention_count: got %0d want 6", k);
        end
        settle();
    endtask

    task automatic test_hold_boundary();
        bit got;
        for (int gap = HOLD; gap <= HOLD + 1; gap++) begin
            got = 1'b0;
            a_req = 1'b1; a_wr = 1'b1; a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                model_eval();
                got = e_a_ack;
                n_vec++;
                if (obs_vec() !== exp_vec()) begin
                    n_err++; $display("FAIL hold_setup%0d: got %h want %h", c, obs_vec(), exp_vec());
                end
                tick();
            end
            a_req = 1'b0;
            for (int c = 1; c < gap; c++) tick();
            b_req = 1'b1; b_wr = 1'b1; b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
            @(negedge clk);
            model_eval();
            n_vec++;
            if (gap == HOLD && {b_ack, dut.state_r} !== {1'b1, 2'd2}) begin
                n_err++; $display("FAIL hold_boundary: ack %b state %0d want 1 2", b_ack, dut.state_r);
            end else if (gap != HOLD && {b_ack, dut.state_r} !== {1'b0, 2'd0}) begin
                n_err++; $display("FAIL hold_expired: ack %b state %0d want 0 0", b_ack, dut.state_r);
            end
            for (int c = 0; c < 4 && b_req; c++) begin
                model_eval();
                if (e_b_ack) begin
                    tick();
                    b_req = 1'b0;
                end else begin
                    tick();
                    @(negedge clk);
                end
            end
            settle();
        end
    endtask

    task automatic test_random();
        bit ack_a, ack_b;
        int pct;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            model_eval();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if ((e_a_rv || e_b_rv) && m_rv_known) begin
                n_vec++;
                if (rdata !== m_rv_data) begin
                    n_err++; $display("FAIL random_rdata%0d: got %h want %h", c, rdata, m_rv_data);
                end
            end
            ack_a = e_a_ack;
            ack_b = e_b_ack;
            tick();
            pct = ((c / 50) % 2 == 1) ? 45 : 6;
            rst = ($urandom_range(0, 199) == 0);
            if (ack_a || !a_req) begin
                a_req = ($urandom_range(0, 99) < pct);
                a_wr = 1'($urandom_range(0, 1)); a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
            end
            if (ack_b || !b_req) begin
                b_req = ($urandom_range(0, 99) < pct);
                b_wr = 1'($urandom_range(0, 1)); b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
            end
        end
        rst = 1'b0;
        settle();
    endtask

    task automatic test_reset_mid_read();
        bit got = 1'b0;
        a_req = 1'b1; a_wr = 1'b0; a_addr = 4'h3;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            model_eval();
            got = e_a_ack;
            tick();
        end
        a_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        model_eval();
        n_vec++;
        if ({got, a_rvalid} !== {1'b1, e_a_rv}) begin
            n_err++; $display("FAIL midread_rvalid: ack %b rvalid %b want 1 0", got, a_rvalid);
        end
        tick();
        rst = 1'b0;
        n_vec++;
        if ({gclk, dut.state_r} !== {1'b0, 2'd0}) begin
            n_err++; $display("FAIL midread_gate: gclk %b state %0d want 0 0", gclk, dut.state_r);
        end
        a_req = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            model_eval();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL midread_reissue%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (e_a_rv) got = 1'b1;
            if (e_a_ack) begin
                tick();
                a_req = 1'b0;
            end else begin
                tick();
            end
        end
        n_vec++;
        if (!got) begin
            n_err++; $display("FAIL midread_reissue_timeout: got no rvalid want rvalid");
        end
        settle();
    endtask

`ifdef CLKGATE_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        a_req = 1'b1; a_wr = 1'b1; a_addr = 4'h7; a_wdata = 8'h3C;
        tick();
        @(negedge clk);
        n_vec++;
        if (gated_cycles !== 16'd11 || gated_cycles !== 16'(m_gated)) begin
            n_err++; $display("FAIL stats_count: got %0d want 11 (model %0d)", gated_cycles, m_gated);
        end
        tick();
        tick();
        a_req = 1'b0;
        settle();
    endtask
`endif

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        m_phase = 0; m_quiet = 0; m_gated = 0; m_tie_b = 1'b0;
        m_rv_a = 1'b0; m_rv_b = 1'b0; m_rv_known = 1'b0; m_rv_data = '0;
        m_last_addr = '0; m_last_d = '0;
        for (int i = 0; i < 16; i++) begin
            m_known[i] = 1'b0;
            m_mem[i] = '0;
        end
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_hold_boundary();
        test_random();
        test_reset_mid_read();
`ifdef CLKGATE_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
